// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mult_share_arb
//  Brief    : Round-robin sharing of one pipelined signed multiplier between
//             two requesters. Operands are sign/zero-extended to WIDTH+1 bits,
//             ownership is tracked through the pipeline, and each product is
//             returned to its owner with a one-cycle done pulse. A per-port
//             kill drops that port's in-flight result.
//
//             Timing: a request acked in cycle k has its operands on
//             mult_a/mult_b in cycle k+1. The external multiplier must present
//             the matching product on mult_out in cycle k+LATENCY (that is,
//             LATENCY-1 register stages after mult_a/mult_b). The done pulse
//             and result follow in cycle k+LATENCY+1.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_share_arb #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  // port 0 : execute-stage MUL/IMUL
  input  logic               req0,
  input  logic               signed0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               kill0,
  output logic               ack0,
  output logic               done0,
  output logic [2*WIDTH-1:0] result0,
  // port 1 : microcode / address-scaling path
  input  logic               req1,
  input  logic               signed1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  input  logic               kill1,
  output logic               ack1,
  output logic               done1,
  output logic [2*WIDTH-1:0] result1,
  // shared multiplier
  output logic [WIDTH:0]     mult_a,
  output logic [WIDTH:0]     mult_b,
  input  logic [2*WIDTH+1:0] mult_out
);

  localparam logic c_PORT0 = 1'b0;
  localparam logic c_PORT1 = 1'b1;

  // round-robin pointer: names the port that wins the next tie
  logic               r_ptr;
  // one outstanding op per port
  logic               r_busy0;
  logic               r_busy1;
  // ownership tracker, stage 0 aligned with mult_a/mult_b,
  // stage LATENCY-1 aligned with mult_out
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_own;

  logic               w_elig0;
  logic               w_elig1;
  logic               w_win_vld;
  logic               w_win_id;
  logic [WIDTH:0]     w_opa;
  logic [WIDTH:0]     w_opb;
  logic [LATENCY-1:0] w_keep;
  logic               w_fin0;
  logic               w_fin1;
  // the two guard bits of the 66-bit product never reach a result
  logic [1:0]         w_unused_hi;

  assign w_unused_hi = mult_out[2*WIDTH+1:2*WIDTH];

  // a port competes only when requesting, idle and not being killed;
  // acks are suppressed while reset is held so outputs read 0 at once
  assign w_elig0 = req0 & ~r_busy0 & ~kill0 & ~rst;
  assign w_elig1 = req1 & ~r_busy1 & ~kill1 & ~rst;

  // pick at most one winner per cycle; the pointer breaks ties
  always_comb begin
    w_win_vld = w_elig0 | w_elig1;
    w_win_id  = c_PORT0;
    if (w_elig0 && w_elig1) begin
      w_win_id = r_ptr;
    end else if (w_elig1) begin
      w_win_id = c_PORT1;
    end
  end

  assign ack0 = w_win_vld & (w_win_id == c_PORT0);
  assign ack1 = w_win_vld & (w_win_id == c_PORT1);

  // extend the winner's operands to WIDTH+1 bits so one signed multiplier
  // serves both signed and unsigned requests
  always_comb begin
    w_opa = '0;
    w_opb = '0;
    if (w_win_vld) begin
      if (w_win_id == c_PORT1) begin
        w_opa = {signed1 & a1[WIDTH-1], a1};
        w_opb = {signed1 & b1[WIDTH-1], b1};
      end else begin
        w_opa = {signed0 & a0[WIDTH-1], a0};
        w_opb = {signed0 & b0[WIDTH-1], b0};
      end
    end
  end

  // a tracker entry survives unless its owner's kill is asserted this cycle
  assign w_keep = ~((r_own & {LATENCY{kill1}}) | (~r_own & {LATENCY{kill0}}));

  // completion: last stage valid and not being killed in this very cycle
  assign w_fin0 = r_vld[LATENCY-1] & w_keep[LATENCY-1] & (r_own[LATENCY-1] == c_PORT0);
  assign w_fin1 = r_vld[LATENCY-1] & w_keep[LATENCY-1] & (r_own[LATENCY-1] == c_PORT1);

  // pointer moves to the other port only after a real contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= c_PORT0;
    end else if (w_elig0 && w_elig1) begin
      r_ptr <= ~r_ptr;
    end
  end

  // operand registers feeding the multiplier, zeroed when nobody wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_a <= '0;
      mult_b <= '0;
    end else begin
      mult_a <= w_opa;
      mult_b <= w_opb;
    end
  end

  // ownership shift register, kills squash entries as they move along
  generate
    if (LATENCY > 1) begin : g_track_deep
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= '0;
          r_own <= '0;
        end else begin
          r_vld <= {r_vld[LATENCY-2:0] & w_keep[LATENCY-2:0], w_win_vld};
          r_own <= {r_own[LATENCY-2:0], w_win_id};
        end
      end
    end else begin : g_track_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= '0;
          r_own <= '0;
        end else begin
          r_vld <= w_win_vld;
          r_own <= w_win_id;
        end
      end
    end
  endgenerate

  // register done pulses and capture products for their owners
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done0   <= 1'b0;
      done1   <= 1'b0;
      result0 <= '0;
      result1 <= '0;
    end else begin
      done0 <= w_fin0;
      done1 <= w_fin1;
      if (w_fin0) begin
        result0 <= mult_out[2*WIDTH-1:0];
      end
      if (w_fin1) begin
        result1 <= mult_out[2*WIDTH-1:0];
      end
    end
  end

  // busy from ack until the end of the done cycle, or until killed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy0 <= 1'b0;
      r_busy1 <= 1'b0;
    end else begin
      if (ack0) begin
        r_busy0 <= 1'b1;
      end else if (done0 || kill0) begin
        r_busy0 <= 1'b0;
      end
      if (ack1) begin
        r_busy1 <= 1'b1;
      end else if (done1 || kill1) begin
        r_busy1 <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_share_arb
//  Brief    : Self-checking bench for mult_share_arb. Provides the external
//             multiplier (one product register after mult_a/mult_b) and a
//             cycle-level reference model of acks, dones and results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_arb;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, signed0, kill0, req1, signed1, kill1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           ack0, done0, ack1, done1;
  logic [2*W-1:0] result0, result1;
  logic [W:0]     mult_a, mult_b;
  logic [2*W+1:0] mult_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_share_arb #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .signed0(signed0), .a0(a0), .b0(b0), .kill0(kill0),
    .ack0(ack0), .done0(done0), .result0(result0),
    .req1(req1), .signed1(signed1), .a1(a1), .b1(b1), .kill1(kill1),
    .ack1(ack1), .done1(done1), .result1(result1),
    .mult_a(mult_a), .mult_b(mult_b), .mult_out(mult_out)
  );

  // external multiplier: product register behind the DUT operand registers
  always_ff @(posedge clk) mult_out <= $signed(mult_a) * $signed(mult_b);

  // ---------------- reference model state ----------------
  bit          m_ptr;
  bit          m_busy [2];
  bit          m_pend [2];
  int          m_due  [2];
  logic [63:0] m_prod [2];
  logic [63:0] m_res  [2];
  logic [32:0] m_ma, m_mb;
  int          cyc = 0;

  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    if (s) return sx * sy;
    return ux * uy;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_ma  = '0;
    m_mb  = '0;
    for (int p = 0; p < 2; p++) begin
      m_busy[p] = 0; m_pend[p] = 0; m_due[p] = 0; m_prod[p] = '0; m_res[p] = '0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // one clock cycle: drive inputs, predict, compare, advance the model
  task automatic cycle(input bit [1:0] r, input bit [1:0] s, input bit [1:0] k,
                       input logic [31:0] x0, input logic [31:0] y0,
                       input logic [31:0] x1, input logic [31:0] y1,
                       output bit [1:0] ack_o, output bit [1:0] done_o);
    bit [1:0]    e, w, d;
    logic [31:0] x [2];
    logic [31:0] y [2];
    logic [32:0] na, nb;
    x[0] = x0; y[0] = y0; x[1] = x1; y[1] = y1;
    @(posedge clk); #1;
    req0 = r[0]; signed0 = s[0]; kill0 = k[0]; a0 = x0; b0 = y0;
    req1 = r[1]; signed1 = s[1]; kill1 = k[1]; a1 = x1; b1 = y1;
    for (int p = 0; p < 2; p++) begin
      d[p] = m_pend[p] && (m_due[p] == cyc);
      if (d[p]) m_res[p] = m_prod[p];
      e[p] = r[p] && !m_busy[p] && !k[p];
    end
    w[0] = e[0] && (!e[1] || !m_ptr);
    w[1] = e[1] && (!e[0] || m_ptr);
    if (e == 2'b11) m_ptr = !m_ptr;
    na = '0; nb = '0;
    for (int p = 0; p < 2; p++) begin
      if (w[p]) begin
        na = {s[p] & x[p][31], x[p]};
        nb = {s[p] & y[p][31], y[p]};
      end
    end
    #3;
    chk("ack0", ack0, w[0]);
    chk("ack1", ack1, w[1]);
    chk("done0", done0, d[0]);
    chk("done1", done1, d[1]);
    chk("result0", result0, m_res[0]);
    chk("result1", result1, m_res[1]);
    chk("mult_a", mult_a, m_ma);
    chk("mult_b", mult_b, m_mb);
    ack_o  = {ack1, ack0};
    done_o = {done1, done0};
    m_ma = na;
    m_mb = nb;
    for (int p = 0; p < 2; p++) begin
      if (d[p]) m_pend[p] = 0;
      if (k[p] && m_pend[p] && m_due[p] > cyc) m_pend[p] = 0;
      if (w[p]) begin
        m_busy[p] = 1;
        m_pend[p] = 1;
        m_due[p]  = cyc + LAT + 1;
        m_prod[p] = ref_mul(s[p], x[p], y[p]);
      end else if (d[p] || k[p]) begin
        m_busy[p] = 0;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit [1:0] ak, dn;
    for (int i = 0; i < n; i++) cycle(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, ak, dn);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},  {ack1, ack0}, 0);
    chk({tag, "_done"}, {done1, done0}, 0);
    chk({tag, "_res0"}, result0, 0);
    chk({tag, "_res1"}, result1, 0);
    chk({tag, "_ma"},   mult_a, 0);
    chk({tag, "_mb"},   mult_b, 0);
  endtask

  typedef struct {
    bit          port;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    bit [1:0]    ak, dn, rr, ss, kk;
    bit          seen;
    logic [63:0] got;

    vecs[0] = '{0, 1, 32'hFFFF_FFFF, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[1] = '{0, 0, 32'hFFFF_FFFF, 32'h0000_0003, 64'h0000_0002_FFFF_FFFD};
    vecs[2] = '{1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[3] = '{0, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[4] = '{1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[5] = '{1, 0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

    // reset state
    rst = 1'b1;
    req0 = 0; signed0 = 0; kill0 = 0; a0 = 0; b0 = 0;
    req1 = 0; signed1 = 0; kill1 = 0; a1 = 0; b1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // table: single-port ops, ack same cycle, done LAT+1 cycles later
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].port) cycle(2'b10, {vecs[i].sgn, 1'b0}, 2'b00, 0, 0, vecs[i].a, vecs[i].b, ak, dn);
      else              cycle(2'b01, {1'b0, vecs[i].sgn}, 2'b00, vecs[i].a, vecs[i].b, 0, 0, ak, dn);
      chk("tbl_ack", ak[vecs[i].port], 1);
      seen = 0;
      for (int j = 0; j < 8 && !seen; j++) begin
        cycle(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, ak, dn);
        if (dn[vecs[i].port]) begin
          seen = 1;
          got  = vecs[i].port ? result1 : result0;
          chk("tbl_latency", j + 1, LAT + 1);
          chk("tbl_result", got, vecs[i].exp);
        end
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL tbl_done: vector %0d got no done, required one within 8 cycles", i);
      end
    end

    // contention: both ports every cycle
    for (int j = 0; j < 24; j++) begin
      cycle(2'b11, 2'b11, 2'b00, 2, 3, 5, 7, ak, dn);
      if (j == 0) chk("rr_first", ak, 2'b01);
      if (j == 1) chk("rr_second", ak, 2'b10);
      if (dn[0]) chk("rr_res0", result0, 6);
      if (dn[1]) chk("rr_res1", result1, 35);
    end
    idle(6);

    // kill1 in the cycle before its completion
    cycle(2'b10, 2'b00, 2'b00, 0, 0, 9, 4, ak, dn);
    chk("k1_ack", ak[1], 1);
    idle(1);
    cycle(2'b00, 2'b00, 2'b10, 0, 0, 0, 0, ak, dn);
    for (int j = 0; j < 4; j++) begin
      cycle(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, ak, dn);
      chk("k1_nodone", dn[1], 0);
    end
    cycle(2'b10, 2'b00, 2'b00, 0, 0, 9, 4, ak, dn);
    chk("k1_reack", ak[1], 1);
    idle(5);

    // kill0 in the cycle port 1 completes
    cycle(2'b10, 2'b10, 2'b00, 0, 0, 32'hFFFF_FFFE, 5, ak, dn);
    idle(1);
    cycle(2'b00, 2'b00, 2'b01, 0, 0, 0, 0, ak, dn);
    cycle(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, ak, dn);
    chk("k0_done1", dn[1], 1);
    chk("k0_res1", result1, 64'hFFFF_FFFF_FFFF_FFF6);
    idle(3);

    // reset with two ops in flight
    cycle(2'b01, 2'b00, 2'b00, 3, 4, 0, 0, ak, dn);
    cycle(2'b10, 2'b00, 2'b00, 0, 0, 6, 7, ak, dn);
    #2;
    req0 = 0; req1 = 0; kill0 = 0; kill1 = 0;
    rst = 1'b1;
    #1;
    chk_all_zero("arst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      cycle(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, ak, dn);
      chk("arst_nodone", dn, 0);
    end
    cycle(2'b11, 2'b00, 2'b00, 1, 1, 1, 1, ak, dn);
    chk("arst_ptr", ak, 2'b01);
    idle(6);

    // randomized traffic against the model
    for (int j = 0; j < 600; j++) begin
      rr = 2'($urandom_range(0, 3));
      ss = 2'($urandom_range(0, 3));
      kk[0] = ($urandom_range(0, 9) == 0);
      kk[1] = ($urandom_range(0, 9) == 0);
      cycle(rr, ss, kk, $urandom, $urandom, $urandom, $urandom, ak, dn);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
